// File: rtl/btn_conditioner_pkg.sv
// Shared helpers for the push-button conditioning slice.
package btn_conditioner_pkg;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: polarity fix, 2-flop synchroniser, debounce counter, edge pulses.
module btn_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 250000,
  parameter bit          INVERT    = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw ^ INVERT;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any return to the stable level restarts the interval from zero.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        rise  <= s2;
        fall  <= ~s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Board input stage: per-button debounce with edge pulses, plus long-press core reset pulse.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned             N_BTN       = 2,
  parameter logic [N_BTN-1:0]        ACTIVE_LOW  = '0,
  parameter int unsigned             DB_CYCLES   = 250000,
  parameter int unsigned             LONG_CYCLES = 50000000,
  parameter int unsigned             RST_IDX     = 0,
  parameter int unsigned             RST_LEN     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] rise_o,
  output logic [N_BTN-1:0] fall_o,
  output logic             core_rst_o
);

  typedef enum logic [1:0] {IDLE, HOLD, FIRE, WAIT_REL} state_t;

  localparam int unsigned   HW     = $clog2(LONG_CYCLES + 1);
  localparam int unsigned   PW     = cnt_width(RST_LEN);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(RST_LEN - 1);

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .INVERT    (ACTIVE_LOW[g])
    ) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (btn_i[g]),
      .level (btn_o[g]),
      .rise  (rise_o[g]),
      .fall  (fall_o[g])
    );
  end

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [PW-1:0] pcnt;
  logic          pulse;
  logic          held;

  assign held = btn_o[RST_IDX];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
      pcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (held) begin
            state <= HOLD;
            hcnt  <= HW'(1);
          end
        end
        HOLD: begin
          if (!held) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (hcnt == H_LAST) begin
            state <= FIRE;
            pcnt  <= '0;
            pulse <= 1'b1;
          end else if (hcnt != '1) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        // Release is ignored here so the pulse always runs its full length.
        FIRE: begin
          if (pcnt == P_LAST) begin
            state <= WAIT_REL;
            pulse <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!held) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_rst_o = reset | pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a window-based reference model.
module tb_btn_conditioner;

  localparam int         N_BTN       = 2;
  localparam logic [1:0] ACTIVE_LOW  = 2'b01;
  localparam int         DB_CYCLES   = 4;
  localparam int         LONG_CYCLES = 16;
  localparam int         RST_IDX     = 1;
  localparam int         RST_LEN     = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_i = 2'b01;
  logic [1:0] btn_o;
  logic [1:0] rise_o;
  logic [1:0] fall_o;
  logic       core_rst_o;

  always #5 clock = ~clock;

  btn_conditioner #(
    .N_BTN       (N_BTN),
    .ACTIVE_LOW  (ACTIVE_LOW),
    .DB_CYCLES   (DB_CYCLES),
    .LONG_CYCLES (LONG_CYCLES),
    .RST_IDX     (RST_IDX),
    .RST_LEN     (RST_LEN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_i      (btn_i),
    .btn_o      (btn_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .core_rst_o (core_rst_o)
  );

  typedef struct packed {
    logic [1:0] btn;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       pulse;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: a level flips once the last DB_CYCLES synchronised samples all
  // disagree with it and at least DB_CYCLES edges have passed since the last flip/reset.
  // The reset pulse fires when the level has been high for exactly LONG_CYCLES edges.
  logic [1:0] hist[$];
  logic [1:0] m_btn = 2'b00;
  int         last_flip[2];
  int         cyc = 0;
  int         run = 0;
  int         pulse_rem = 0;

  always @(posedge clock) begin : model
    exp_t       e;
    logic [1:0] flip;
    logic       all_diff;
    logic       fire;
    if (hist.size() == 0) for (int i = 0; i < 8; i++) hist.push_back(2'b00);
    cyc++;
    e = '0;
    if (reset) begin
      hist[hist.size()-1] = 2'b00;
      hist.push_back(2'b00);
      m_btn        = 2'b00;
      last_flip[0] = cyc;
      last_flip[1] = cyc;
      run          = 0;
      pulse_rem    = 0;
    end else begin
      hist.push_back(btn_i ^ ACTIVE_LOW);
      fire = (run == LONG_CYCLES);
      flip = 2'b00;
      for (int b = 0; b < N_BTN; b++) begin
        if (cyc - last_flip[b] >= DB_CYCLES) begin
          all_diff = 1'b1;
          for (int k = 2; k <= DB_CYCLES + 1; k++)
            if (hist[hist.size()-1-k][b] == m_btn[b]) all_diff = 1'b0;
          if (all_diff) begin
            flip[b]      = 1'b1;
            last_flip[b] = cyc;
          end
        end
      end
      e.rise = flip & ~m_btn;
      e.fall = flip & m_btn;
      m_btn  = m_btn ^ flip;
      if (fire) pulse_rem = RST_LEN;
      e.pulse = (pulse_rem > 0);
      if (pulse_rem > 0) pulse_rem--;
      run = m_btn[RST_IDX] ? ((run < 1000) ? run + 1 : run) : 0;
    end
    e.btn = m_btn;
    while (hist.size() > 16) void'(hist.pop_front());
    sb.push_back(e);
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("btn_o", btn_o, e.btn);
      check("rise_o", rise_o, e.rise);
      check("fall_o", fall_o, e.fall);
      check("core_rst_o", {1'b0, core_rst_o}, {1'b0, reset | e.pulse});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Edges from the current input change until the selected pulse appears.
  task automatic wait_edge(input string name, input int idx, input bit is_rise, input int exp_n);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1);
      n++;
      if (is_rise ? rise_o[idx] : fall_o[idx]) found = 1'b1;
    end
    n_checks++;
    if (!found || n != exp_n) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (found=%0b) expected %0d", name, n, found, exp_n);
    end
  endtask

  task automatic check_pulse(input int exp_start, input int exp_width);
    int  m;
    int  w;
    bit  seen;
    m    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      m++;
      if (core_rst_o) seen = 1'b1;
    end
    w = seen ? 1 : 0;
    while (seen && core_rst_o && w < 10) begin
      step(1);
      if (core_rst_o) w++;
    end
    n_checks++;
    if (!seen || m != exp_start || w != exp_width) begin
      n_fail++;
      $display("FAIL long_press_pulse: start %0d width %0d expected start %0d width %0d",
               m, w, exp_start, exp_width);
    end
  endtask

  initial begin : stimulus
    reset = 1'b1;
    btn_i = 2'b01;
    step(3);
    reset = 1'b0;
    step(10);

    btn_i[1] = 1'b1;
    wait_edge("clean_press", 1, 1'b1, 6);
    step(5);
    btn_i[1] = 1'b0;
    step(20);

    btn_i[1] = 1'b1; step(2);
    btn_i[1] = 1'b0; step(2);
    btn_i[1] = 1'b1;
    wait_edge("bounce_press", 1, 1'b1, 6);
    step(3);
    btn_i[1] = 1'b0;
    step(20);

    btn_i[0] = 1'b0;
    wait_edge("active_low_press", 0, 1'b1, 6);
    step(8);
    btn_i[0] = 1'b1;
    wait_edge("active_low_release", 0, 1'b0, 6);
    step(15);

    btn_i[1] = 1'b1;
    wait_edge("long_press_rise", 1, 1'b1, 6);
    check_pulse(16, 3);
    step(15);
    btn_i[1] = 1'b0;
    step(20);
    btn_i[1] = 1'b1;
    wait_edge("long_press_again", 1, 1'b1, 6);
    check_pulse(16, 3);
    step(15);
    btn_i[1] = 1'b0;
    step(20);

    btn_i[1] = 1'b1; step(10);
    btn_i[1] = 1'b0; step(20);

    btn_i[1] = 1'b1;
    wait_edge("fire_then_reset", 1, 1'b1, 6);
    step(17);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(40);
    btn_i[1] = 1'b0;
    step(20);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end else begin
        btn_i = 2'($urandom);
        step(int'($urandom_range(1, 24)));
      end
    end

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: stimulus did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
